// File: rtl/psubsb_seq_if.sv
// Handshake/data bundle for the packed saturating subtractor.
// start is sampled only while busy=0; done pulses for one cycle with Diff/Sat final.
interface psubsb_seq_if;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic [3:0]  Sat;

    modport master (
        output start, A, B,
        input  busy, done, Diff, Sat
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Sat
    );
endinterface

// File: rtl/psubsb_seq.sv
// Multi-cycle packed saturating subtractor: four signed 4-bit lanes of A-B,
// one lane per cycle, each clamped to [-8, 7] with a per-lane saturation flag.
module psubsb_seq (
    input  logic               clk,
    input  logic               rst_n,
    psubsb_seq_if.slave        bus,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_lane;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_diff;
    logic [3:0]  r_sat;

    logic        w_accept;
    logic [3:0]  w_a_lane;
    logic [3:0]  w_b_lane;
    logic [4:0]  w_d;
    logic [3:0]  w_res;
    logic        w_sat;

    // A new request is taken whenever the unit is not mid-operation.
    assign w_accept = bus.start && (r_state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? RUN : IDLE;
            RUN:     w_next = (r_lane == 2'd3) ? DONE : RUN;
            DONE:    w_next = w_accept ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Sign-extend both nibbles to 5 bits; the difference always fits in [-15, 15].
    always_comb begin
        w_a_lane = r_a[{r_lane, 2'b00} +: 4];
        w_b_lane = r_b[{r_lane, 2'b00} +: 4];
        w_d      = {w_a_lane[3], w_a_lane} - {w_b_lane[3], w_b_lane};
        w_res    = w_d[3:0];
        w_sat    = 1'b0;
        if ($signed(w_d) > 5'sd7) begin
            w_res = 4'h7;
            w_sat = 1'b1;
        end else if ($signed(w_d) < -5'sd8) begin
            w_res = 4'h8;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= 2'd0;
            r_a    <= 16'h0000;
            r_b    <= 16'h0000;
            r_diff <= 16'h0000;
            r_sat  <= 4'h0;
        end else if (w_accept) begin
            r_lane <= 2'd0;
            r_a    <= bus.A;
            r_b    <= bus.B;
            r_diff <= 16'h0000;
            r_sat  <= 4'h0;
        end else if (r_state == RUN) begin
            r_diff[{r_lane, 2'b00} +: 4] <= w_res;
            r_sat[r_lane]                <= w_sat;
            r_lane                       <= r_lane + 2'd1;
        end
    end

    assign bus.busy    = (r_state == RUN);
    assign bus.done    = (r_state == DONE);
    assign bus.Diff    = r_diff;
    assign bus.Sat     = r_sat;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_psubsb_seq.sv
// Self-checking bench for psubsb_seq: vector table, handshake corner cases,
// and randomized operations against a lane-arithmetic reference model.
module tb_psubsb_seq;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    psubsb_seq_if bus ();

    psubsb_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [19:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic [3:0]  sat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: per-lane signed subtraction with integer clamping; returns {Sat, Diff}.
    function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] diff;
        logic [3:0]  sat;
        logic [3:0]  an;
        logic [3:0]  bn;
        int av;
        int bv;
        int d;
        diff = 16'h0;
        sat  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            an = a[i*4 +: 4];
            bn = b[i*4 +: 4];
            av = (an >= 8) ? int'(an) - 16 : int'(an);
            bv = (bn >= 8) ? int'(bn) - 16 : int'(bn);
            d  = av - bv;
            if (d > 7) begin
                d = 7;
                sat[i] = 1'b1;
            end else if (d < -8) begin
                d = -8;
                sat[i] = 1'b1;
            end
            diff[i*4 +: 4] = d[3:0];
        end
        return {sat, diff};
    endfunction

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called just after the accepting edge; returns at the negedge where done is seen.
    task automatic wait_done(output int lat, output int busy_cnt, output logic [19:0] first_out);
        lat       = 0;
        busy_cnt  = 0;
        first_out = 20'hx;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            lat++;
            if (c == 0) first_out = {bus.Sat, bus.Diff};
            if (bus.done) return;
            if (bus.busy) busy_cnt++;
        end
        check("done_timeout", 20'd0, 20'd1);
        lat = -1;
    endtask

    int          lat;
    int          bcnt;
    int          done_cnt;
    logic [19:0] first;
    logic [19:0] exp;

    initial begin
        vecs[0] = '{16'h5432, 16'h1111, 16'h4321, 4'h0};
        vecs[1] = '{16'h7777, 16'h8888, 16'h7777, 4'hF};
        vecs[2] = '{16'h7801, 16'h8110, 16'h78F1, 4'hC};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 4'h0};
        vecs[4] = '{16'h8888, 16'h7777, 16'h8888, 4'hF};
        vecs[5] = '{16'h0F0F, 16'h0101, 16'h0E0E, 4'h0};
        vecs[6] = '{16'h7070, 16'hF0F0, 16'h7070, 4'hA};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = 16'h0;
        bus.B     = 16'h0;
        #1;
        check("reset_outputs", {bus.Sat, bus.Diff}, 20'h0);
        check("reset_flags", {18'h0, bus.busy, bus.done}, 20'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_state", {18'h0, dbg_state}, 20'h0);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt, first);
            check($sformatf("vec%0d_latency", i), lat, 5);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, 4);
            check($sformatf("vec%0d_first_cycle_clear", i), first & 20'hFFFF0, 20'h0);
            check($sformatf("vec%0d_result", i), {bus.Sat, bus.Diff}, {vecs[i].sat, vecs[i].diff});
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), {19'h0, bus.done}, 20'h0);
            check($sformatf("vec%0d_hold", i), {bus.Sat, bus.Diff}, {vecs[i].sat, vecs[i].diff});
        end

        // Start and input changes during RUN are ignored
        start_op(16'h5432, 16'h1111);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        check("ignored_start_done_count", done_cnt, 1);
        check("ignored_start_result", {bus.Sat, bus.Diff}, 20'h04321);

        // Back-to-back: start asserted in the done cycle
        start_op(16'h5432, 16'h1111);
        wait_done(lat, bcnt, first);
        check("b2b_first_result", {bus.Sat, bus.Diff}, 20'h04321);
        bus.A     = 16'h8888;
        bus.B     = 16'h1111;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_accepted", {19'h0, bus.busy}, 20'h1);
        wait_done(lat, bcnt, first);
        check("b2b_second_latency", lat, 5);
        check("b2b_second_result", {bus.Sat, bus.Diff}, 20'hF8888);

        // Asynchronous reset in the middle of RUN
        start_op(16'h5432, 16'h1111);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {bus.Sat, bus.Diff}, 20'h0);
        check("midreset_flags", {18'h0, bus.busy, bus.done}, 20'h0);
        check("midreset_state", {18'h0, dbg_state}, 20'h0);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("midreset_no_done", done_cnt, 0);
        start_op(16'h5432, 16'h1111);
        wait_done(lat, bcnt, first);
        check("post_reset_result", {bus.Sat, bus.Diff}, 20'h04321);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom_range(0, 16'hFFFF));
            rb = 16'($urandom_range(0, 16'hFFFF));
            exp_q.push_back(ref_model(ra, rb));
            start_op(ra, rb);
            wait_done(lat, bcnt, first);
            exp = exp_q.pop_front();
            check($sformatf("rand%0d_result", i), {bus.Sat, bus.Diff}, exp);
            if (i % 8 == 0) check($sformatf("rand%0d_latency", i), lat, 5);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
